// File: rtl/spectrum_rx_if.sv
// Host-side FIFO read bus of the spectrum receiver.
// master = host logic, slave = spectrum_rx.
interface spectrum_rx_if #(
  parameter int DEPTH = 16
);
  logic                     rd_en;
  logic [15:0]              dout;
  logic                     empty;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic                     clr_ovf;

  modport master (
    output rd_en, clr_ovf,
    input  dout, empty, level, overflow
  );

  modport slave (
    input  rd_en, clr_ovf,
    output dout, empty, level, overflow
  );
endinterface

// File: rtl/spectrum_rx.sv
// Atlas-bus spectrum link receiver: BCLK/LRCLK framed serial words into a DEPTH x 16 FIFO.
// Optional SPECTRUM_RX_ERRCNT_EN adds a saturating err_count output.
module spectrum_rx #(
  parameter int DEPTH    = 16,
  parameter int HEADROOM = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic IFCLK,
  input  logic reset_n,
  input  logic BCLK,
  input  logic LRCLK,
  input  logic SPEC_DATA,
  output logic SPEC_FULL,
  spectrum_rx_if.slave host
`ifdef SPECTRUM_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, SHIFT, PUSH, WAITHI} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sync1_reg, sync2_reg;
  logic            bclk_hist_reg;
  logic            lr_prev_reg;
  logic [15:0]     sr_reg;
  logic [3:0]      bitcnt_reg;
  logic [TW-1:0]   tcnt_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic            full_flag_reg;
  logic            overflow_reg;
  logic [15:0]     mem [DEPTH];

  logic brise, lr_s, data_s, abort, push, drop, pop, fifo_full;

  // Bits: [2]=BCLK, [1]=LRCLK, [0]=SPEC_DATA
  always_ff @(posedge IFCLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg     <= 3'b111;
      sync2_reg     <= 3'b111;
      bclk_hist_reg <= 1'b1;
    end else begin
      sync1_reg     <= {BCLK, LRCLK, SPEC_DATA};
      sync2_reg     <= sync1_reg;
      bclk_hist_reg <= sync2_reg[2];
    end
  end

  assign brise     = sync2_reg[2] & ~bclk_hist_reg;
  assign lr_s      = sync2_reg[1];
  assign data_s    = sync2_reg[0];
  assign fifo_full = (level_reg == (AW+1)'(DEPTH));
  assign push      = (state_reg == PUSH) && !fifo_full;
  assign drop      = (state_reg == PUSH) && fifo_full;
  assign pop       = host.rd_en && (level_reg != '0);

  always_ff @(posedge IFCLK or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    abort      = 1'b0;
    case (state_reg)
      IDLE:   if (brise && !lr_s && lr_prev_reg) state_next = ARM;
      ARM:    state_next = SHIFT;
      SHIFT: begin
        if (tcnt_reg == TW'(TIMEOUT)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (brise) begin
          if (lr_s) begin
            abort      = 1'b1;
            state_next = IDLE;
          end else if (bitcnt_reg == 4'd15) begin
            state_next = PUSH;
          end
        end
      end
      PUSH:   state_next = WAITHI;
      WAITHI: if (lr_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // lr_prev resets low so a word already in flight at reset is never picked up mid-frame
  always_ff @(posedge IFCLK or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev_reg <= 1'b0;
      sr_reg      <= '0;
      bitcnt_reg  <= '0;
      tcnt_reg    <= '0;
    end else begin
      if (brise) lr_prev_reg <= lr_s;
      if (state_reg == ARM) begin
        sr_reg     <= '0;
        bitcnt_reg <= '0;
        tcnt_reg   <= '0;
      end else if (state_reg == SHIFT) begin
        if (brise) begin
          tcnt_reg <= '0;
          if (!lr_s) begin
            sr_reg     <= {sr_reg[14:0], data_s};
            bitcnt_reg <= bitcnt_reg + 4'd1;
          end
        end else begin
          tcnt_reg <= tcnt_reg + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge IFCLK) begin
    if (push) mem[wr_ptr_reg] <= sr_reg;
  end

  always_ff @(posedge IFCLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      full_flag_reg <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
      if (drop)              overflow_reg <= 1'b1;
      else if (host.clr_ovf) overflow_reg <= 1'b0;
      // Only refreshed between words so the transmitter sees a stable throttle per word
      if (state_reg == IDLE && lr_s)
        full_flag_reg <= (level_reg >= (AW+1)'(DEPTH - HEADROOM));
    end
  end

  assign SPEC_FULL     = full_flag_reg;
  assign host.empty    = (level_reg == '0);
  assign host.level    = level_reg;
  assign host.overflow = overflow_reg;
  assign host.dout     = (level_reg == '0) ? 16'h0000 : mem[rd_ptr_reg];

`ifdef SPECTRUM_RX_ERRCNT_EN
  logic [7:0] err_count_reg;
  logic       err_evt;
  assign err_evt = abort | drop;

  always_ff @(posedge IFCLK or negedge reset_n) begin
    if (!reset_n)
      err_count_reg <= '0;
    else if (host.clr_ovf)
      err_count_reg <= err_evt ? 8'd1 : 8'd0;
    else if (err_evt && err_count_reg != 8'hFF)
      err_count_reg <= err_count_reg + 8'd1;
  end

  assign err_count = err_count_reg;
`endif
endmodule

// File: tb/tb_spectrum_rx.sv
// Directed bench for spectrum_rx: BCLK = IFCLK/8, words framed by an LRCLK fall.
module tb_spectrum_rx;
  logic IFCLK, reset_n, BCLK, LRCLK, SPEC_DATA, SPEC_FULL;
`ifdef SPECTRUM_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif
  int n_total = 0;
  int n_bad   = 0;

  spectrum_rx_if #(.DEPTH(16)) bus ();

  spectrum_rx #(.DEPTH(16), .HEADROOM(4), .TIMEOUT(255)) dut (
    .IFCLK     (IFCLK),
    .reset_n   (reset_n),
    .BCLK      (BCLK),
    .LRCLK     (LRCLK),
    .SPEC_DATA (SPEC_DATA),
    .SPEC_FULL (SPEC_FULL),
    .host      (bus.slave)
`ifdef SPECTRUM_RX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial begin
    IFCLK = 1'b0;
    forever #5 IFCLK = ~IFCLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One BCLK period; LRCLK and data change on the falling edge
  task automatic bit_cycle(input logic lr, input logic d);
    BCLK = 1'b0; LRCLK = lr; SPEC_DATA = d;
    #40;
    BCLK = 1'b1;
    #40;
  endtask

  task automatic send_word(input logic [15:0] w, input int nbits);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) bit_cycle(1'b0, w[15-i]);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    $display("sent word=%04h bits=%0d level=%0d", w, nbits, bus.level);
  endtask

  task automatic pop_one(output logic [15:0] w);
    @(negedge IFCLK);
    w = bus.dout;
    bus.rd_en = 1'b1;
    @(negedge IFCLK);
    bus.rd_en = 1'b0;
    $display("pop word=%04h level=%0d", w, bus.level);
  endtask

  logic [15:0] w;

  initial begin
    reset_n = 1'b0; BCLK = 1'b1; LRCLK = 1'b1; SPEC_DATA = 1'b0;
    bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    #41;
    check_eq("rst_full",  SPEC_FULL,    1);
    check_eq("rst_empty", bus.empty,    1);
    check_eq("rst_level", bus.level,    0);
    check_eq("rst_dout",  bus.dout,     0);
    check_eq("rst_ovf",   bus.overflow, 0);
    #39;
    reset_n = 1'b1;

    // Single word
    send_word(16'hA5C3, 16);
    check_eq("w1_empty", bus.empty, 0);
    check_eq("w1_dout",  bus.dout,  16'hA5C3);
    check_eq("w1_level", bus.level, 1);
    check_eq("w1_full",  SPEC_FULL, 0);
    pop_one(w);
    check_eq("w1_popped", bus.empty, 1);

    // Extreme values back-to-back
    send_word(16'h8000, 16);
    send_word(16'h7FFF, 16);
    send_word(16'h0001, 16);
    check_eq("b2b_level", bus.level, 3);
    pop_one(w); check_eq("b2b_0", w, 16'h8000);
    pop_one(w); check_eq("b2b_1", w, 16'h7FFF);
    pop_one(w); check_eq("b2b_2", w, 16'h0001);

    // SPEC_FULL threshold at DEPTH-HEADROOM = 12
    for (int i = 0; i < 12; i++) begin
      send_word(16'h1000 + 16'(i), 16);
      if (i == 10) check_eq("full_after11", SPEC_FULL, 0);
    end
    check_eq("full_after12", SPEC_FULL, 1);
    check_eq("lvl12", bus.level, 12);
    pop_one(w);
    check_eq("thr_head", w, 16'h1000);
    repeat (3) @(negedge IFCLK);
    check_eq("full_release", SPEC_FULL, 0);
    for (int i = 0; i < 11; i++) pop_one(w);
    check_eq("thr_last", w, 16'h100B);
    check_eq("drained", bus.level, 0);

    // Early LRCLK rise after 9 bits aborts the word
    send_word(16'hFFFF, 9);
    check_eq("early_level", bus.level, 0);
    check_eq("early_state", dut.state_reg, 0);
    send_word(16'h1234, 16);
    check_eq("after_abort", bus.dout, 16'h1234);
`ifdef SPECTRUM_RX_ERRCNT_EN
    check_eq("errcnt_1", err_count, 1);
`endif
    pop_one(w);

    // BCLK stalls mid-word for 300 IFCLK cycles
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0);
    bit_cycle(1'b0, 1'b1);
    bit_cycle(1'b0, 1'b0);
    #3000;
    check_eq("tmo_state", dut.state_reg, 0);
    check_eq("tmo_level", bus.level, 0);
    $display("timeout stall done level=%0d", bus.level);

    // Fill to 16, then one more drops and sets overflow
    for (int i = 0; i < 16; i++) send_word(16'h0100 + 16'(i), 16);
    check_eq("fill_ovf", bus.overflow, 0);
    check_eq("fill_level", bus.level, 16);
    send_word(16'hDEAD, 16);
    check_eq("ovf_set", bus.overflow, 1);
    check_eq("ovf_level", bus.level, 16);
    check_eq("ovf_head", bus.dout, 16'h0100);
`ifdef SPECTRUM_RX_ERRCNT_EN
    check_eq("errcnt_3", err_count, 3);
`endif
    @(negedge IFCLK); bus.clr_ovf = 1'b1;
    @(negedge IFCLK); bus.clr_ovf = 1'b0;
    check_eq("ovf_clr", bus.overflow, 0);
`ifdef SPECTRUM_RX_ERRCNT_EN
    check_eq("errcnt_clr", err_count, 0);
`endif

    // Reset in the middle of a word
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_cycle(1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_empty", bus.empty, 1);
    check_eq("mid_rst_level", bus.level, 0);
    check_eq("mid_rst_dout",  bus.dout, 0);
    check_eq("mid_rst_full",  SPEC_FULL, 1);
    #79;
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) bit_cycle(1'b0, 1'b1);
    bit_cycle(1'b1, 1'b0);
    bit_cycle(1'b1, 1'b0);
    check_eq("post_rst_level", bus.level, 0);
    send_word(16'h5A5A, 16);
    check_eq("post_rst_dout",  bus.dout, 16'h5A5A);
    check_eq("post_rst_lvl1",  bus.level, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
